// File: rtl/bist_ctrl.sv
// BIST sequencer: seeds the LFSR, clears the SISR, runs N_PATTERNS compaction
// cycles, then compares the signature against a golden value and reports done/pass.
module bist_ctrl #(
    parameter int N_PATTERNS = 31,
    parameter int CNT_W      = 5,
    parameter int SIG_W      = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [SIG_W-1:0] i_golden,
    input  logic [SIG_W-1:0] i_sig,
    output logic             o_gen_seed,
    output logic             o_gen_en,
    output logic             o_sisr_clr,
    output logic             o_sisr_en,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [CNT_W-1:0] o_pat_cnt,
    output logic [2:0]       o_state
);

    // Handshake: i_start is a level request sampled only in IDLE and DONE (a
    // start seen in DONE restarts at once); i_abort is sampled only while busy.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_CMP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(N_PATTERNS - 1);

    generate
        if (N_PATTERNS < 1 || N_PATTERNS > (2 ** CNT_W) - 1) begin : g_bad_patterns
            $error("bist_ctrl: N_PATTERNS must lie in 1..2**CNT_W-1");
        end
    endgenerate

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_pat_cnt;
    logic             r_pass;
    logic             w_busy;
    logic             w_abort_hit;
    logic             w_last;

    assign w_busy      = (r_state == S_INIT) || (r_state == S_RUN) || (r_state == S_CMP);
    assign w_abort_hit = i_abort && w_busy;
    assign w_last      = (r_pat_cnt == LP_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_state_nxt = S_INIT;
            S_INIT: w_state_nxt = i_abort ? S_IDLE : S_RUN;
            S_RUN: begin
                if (i_abort)     w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_CMP;
            end
            S_CMP:  w_state_nxt = i_abort ? S_IDLE : S_DONE;
            S_DONE: if (i_start) w_state_nxt = S_INIT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // An abort keeps pat_cnt frozen so the stopping point can be inspected.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_pat_cnt <= '0;
            r_pass    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_abort_hit) begin
                r_pass <= 1'b0;
            end else begin
                case (r_state)
                    S_INIT: r_pat_cnt <= '0;
                    S_RUN:  r_pat_cnt <= r_pat_cnt + CNT_W'(1);
                    S_CMP:  r_pass    <= (i_sig == i_golden);
                    S_DONE: if (i_start) r_pass <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign o_gen_seed = (r_state == S_INIT);
    assign o_sisr_clr = (r_state == S_INIT);
    assign o_gen_en   = (r_state == S_RUN);
    assign o_sisr_en  = (r_state == S_RUN);
    assign o_busy     = w_busy;
    assign o_done     = (r_state == S_DONE);
    assign o_pass     = r_pass;
    assign o_pat_cnt  = r_pat_cnt;
    assign o_state    = r_state;

endmodule

// File: tb/tb_bist_ctrl.sv
// Bench for bist_ctrl: a behavioural LFSR/CUT/SISR datapath driven by the DUT
// enables, with a scoreboard of expected {pass, pat_cnt} checked on each done.
module tb_bist_ctrl;

    localparam int CNT_W = 5;
    localparam int SIG_W = 4;
    localparam int NP    = 31;
    localparam int W     = 1 + CNT_W;
    localparam logic [4:0] SEED = 5'b00001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic             start = 1'b0, abort = 1'b0;
    logic [SIG_W-1:0] golden = '0, sig;
    logic             gen_seed, gen_en, sisr_clr, sisr_en, busy, done, pass;
    logic [CNT_W-1:0] pat_cnt;
    logic [2:0]       state;

    logic             start1 = 1'b0;
    logic [SIG_W-1:0] golden1 = '0, sig1;
    logic             gen_seed1, gen_en1, sisr_clr1, sisr_en1, busy1, done1, pass1;
    logic [CNT_W-1:0] pat_cnt1;
    logic [2:0]       state1;

    bist_ctrl #(.N_PATTERNS(NP), .CNT_W(CNT_W), .SIG_W(SIG_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_golden(golden), .i_sig(sig),
        .o_gen_seed(gen_seed), .o_gen_en(gen_en), .o_sisr_clr(sisr_clr),
        .o_sisr_en(sisr_en), .o_busy(busy), .o_done(done), .o_pass(pass),
        .o_pat_cnt(pat_cnt), .o_state(state)
    );

    bist_ctrl #(.N_PATTERNS(1), .CNT_W(CNT_W), .SIG_W(SIG_W)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_abort(1'b0),
        .i_golden(golden1), .i_sig(sig1),
        .o_gen_seed(gen_seed1), .o_gen_en(gen_en1), .o_sisr_clr(sisr_clr1),
        .o_sisr_en(sisr_en1), .o_busy(busy1), .o_done(done1), .o_pass(pass1),
        .o_pat_cnt(pat_cnt1), .o_state(state1)
    );

    function automatic logic [4:0] lfsr_next(input logic [4:0] l);
        return {l[3:0], l[4] ^ l[2]};
    endfunction

    function automatic logic [3:0] cut_fn(input logic [4:0] l);
        return {l[4] ^ l[0], l[3] & l[1], l[2] | l[0], l[1] ^ l[3] ^ l[4]};
    endfunction

    function automatic logic [3:0] sisr_next(input logic [3:0] s, input logic [3:0] d);
        return {s[2], s[1], s[0] ^ s[3], s[3]} ^ d;
    endfunction

    function automatic logic [SIG_W-1:0] golden_sig(input int n);
        logic [4:0] l;
        logic [3:0] s;
        l = SEED;
        s = '0;
        for (int i = 0; i < n; i++) begin
            s = sisr_next(s, cut_fn(l));
            l = lfsr_next(l);
        end
        return s;
    endfunction

    // Datapath models for both DUT instances
    logic [4:0] lfsr = '0, lfsr1 = '0;
    logic [3:0] sisr = '0, sisr1 = '0;
    assign sig  = sisr;
    assign sig1 = sisr1;

    always @(posedge clk) begin
        if (gen_seed) lfsr <= SEED;
        else if (gen_en) lfsr <= lfsr_next(lfsr);
        if (sisr_clr) sisr <= '0;
        else if (sisr_en) sisr <= sisr_next(sisr, cut_fn(lfsr));
        if (gen_seed1) lfsr1 <= SEED;
        else if (gen_en1) lfsr1 <= lfsr_next(lfsr1);
        if (sisr_clr1) sisr1 <= '0;
        else if (sisr_en1) sisr1 <= sisr_next(sisr1, cut_fn(lfsr1));
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];
    logic prev_done = 1'b0;

    // Scoreboard: every rising done pops one expected {pass, pat_cnt}
    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        if (done === 1'b1 && prev_done !== 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_done got={pass,pat_cnt}=%h expected none", {pass, pat_cnt});
            end else begin
                exp_v = exp_q.pop_front();
                if ({pass, pat_cnt} !== exp_v)
                    $display("FAIL sb_result got={pass,pat_cnt}=%h expected %h", {pass, pat_cnt}, exp_v);
                else
                    n_pass++;
            end
        end
        prev_done = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start (plus an optional extra start pulse k edges later)
    // and measure latency and enable activity until done rises.
    task automatic run_to_done(input int pulse_at, output int lat, output int busy_n,
                               output int en_n, output int seed_n, output int clash_n);
        lat = -1; busy_n = 0; en_n = 0; seed_n = 0; clash_n = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_n++;
            if (gen_en && sisr_en) en_n++;
            if (gen_seed && sisr_clr) seed_n++;
            if ((gen_seed && gen_en) || (sisr_clr && sisr_en)) clash_n++;
            start = (k == pulse_at);
            tick();
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if ({gen_seed, gen_en, sisr_clr, sisr_en, busy, done, pass} !== 7'b0)
            $display("FAIL reset_outputs got=%b expected 0000000", {gen_seed, gen_en, sisr_clr, sisr_en, busy, done, pass});
        else n_pass++;
        n_checks++;
        if (pat_cnt !== 5'd0 || state !== 3'd0)
            $display("FAIL reset_cnt_state got cnt=%0d state=%0d expected 0/0", pat_cnt, state);
        else n_pass++;
        n_checks++;
        if ({busy1, done1, pass1, pat_cnt1} !== 8'b0)
            $display("FAIL reset_dut1 got=%b expected 0", {busy1, done1, pass1, pat_cnt1});
        else n_pass++;
        abort = 1'b1;
        tick();
        tick();
        abort = 1'b0;
        n_checks++;
        if (state !== 3'd0 || busy !== 1'b0)
            $display("FAIL idle_hold got state=%0d busy=%b expected 0/0", state, busy);
        else n_pass++;
    endtask

    task automatic test_nominal();
        int lat, busy_n, en_n, seed_n, clash_n;
        golden = golden_sig(NP);
        exp_q.push_back({1'b1, 5'd31});
        run_to_done(-1, lat, busy_n, en_n, seed_n, clash_n);
        n_checks++;
        if (lat !== 33) $display("FAIL nominal_latency got=%0d expected 33", lat);
        else n_pass++;
        n_checks++;
        if (busy_n !== 33 || en_n !== 31 || seed_n !== 1)
            $display("FAIL nominal_enables got busy=%0d en=%0d seed=%0d expected 33/31/1", busy_n, en_n, seed_n);
        else n_pass++;
        n_checks++;
        if (clash_n !== 0) $display("FAIL nominal_exclusive got=%0d expected 0", clash_n);
        else n_pass++;
        n_checks++;
        if (pass !== 1'b1 || pat_cnt !== 5'd31)
            $display("FAIL nominal_result got pass=%b cnt=%0d expected 1/31", pass, pat_cnt);
        else n_pass++;
        abort = 1'b1;
        repeat (3) tick();
        abort = 1'b0;
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b1 || pat_cnt !== 5'd31)
            $display("FAIL done_hold got done=%b pass=%b cnt=%0d expected 1/1/31", done, pass, pat_cnt);
        else n_pass++;
    endtask

    task automatic test_mismatch();
        int lat, busy_n, en_n, seed_n, clash_n;
        golden = golden_sig(NP) ^ 4'b0001;
        exp_q.push_back({1'b0, 5'd31});
        run_to_done(-1, lat, busy_n, en_n, seed_n, clash_n);
        n_checks++;
        if (lat !== 33 || pass !== 1'b0)
            $display("FAIL mismatch got lat=%0d pass=%b expected 33/0", lat, pass);
        else n_pass++;
    endtask

    task automatic test_abort();
        int lat, busy_n, en_n, seed_n, clash_n;
        golden = golden_sig(NP);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if ({busy, done, pass, gen_en} !== 4'b0 || pat_cnt !== 5'd9)
            $display("FAIL abort_state got busy=%b done=%b pass=%b cnt=%0d expected 0/0/0/9", busy, done, pass, pat_cnt);
        else n_pass++;
        exp_q.push_back({1'b1, 5'd31});
        run_to_done(-1, lat, busy_n, en_n, seed_n, clash_n);
        n_checks++;
        if (lat !== 33 || en_n !== 31 || pass !== 1'b1)
            $display("FAIL abort_rerun got lat=%0d en=%0d pass=%b expected 33/31/1", lat, en_n, pass);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int lat, busy_n, en_n, seed_n, clash_n;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        n_checks++;
        if (gen_en !== 1'b1 || pat_cnt !== 5'd19)
            $display("FAIL pre_reset_run got gen_en=%b cnt=%0d expected 1/19", gen_en, pat_cnt);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({gen_seed, gen_en, sisr_clr, sisr_en, busy, done, pass} !== 7'b0 || pat_cnt !== 5'd0)
            $display("FAIL mid_reset got=%b cnt=%0d expected 0/0", {gen_seed, gen_en, sisr_clr, sisr_en, busy, done, pass}, pat_cnt);
        else n_pass++;
        exp_q.push_back({1'b1, 5'd31});
        run_to_done(-1, lat, busy_n, en_n, seed_n, clash_n);
        n_checks++;
        if (lat !== 33 || pass !== 1'b1 || pat_cnt !== 5'd31)
            $display("FAIL reset_rerun got lat=%0d pass=%b cnt=%0d expected 33/1/31", lat, pass, pat_cnt);
        else n_pass++;
    endtask

    task automatic test_start_during_busy();
        int lat, busy_n, en_n, seed_n, clash_n;
        exp_q.push_back({1'b1, 5'd31});
        run_to_done(5, lat, busy_n, en_n, seed_n, clash_n);
        n_checks++;
        if (lat !== 33 || seed_n !== 1)
            $display("FAIL busy_start got lat=%0d seeds=%0d expected 33/1", lat, seed_n);
        else n_pass++;
        repeat (2) tick();
        n_checks++;
        if (done !== 1'b1) $display("FAIL busy_start_done got done=%b expected 1", done);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int rises, done_cyc, first_rise, second_rise;
        logic last_d;
        rises = 0; done_cyc = 0; first_rise = -1; second_rise = -1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_d = 1'b0;
        repeat (3) exp_q.push_back({1'b1, 5'd31});
        for (int i = 0; i < 110; i++) begin
            start = (i < 100);
            tick();
            if (done && !last_d) begin
                rises++;
                if (first_rise < 0) first_rise = i;
                else if (second_rise < 0) second_rise = i;
            end
            if (done && i < 100) done_cyc++;
            last_d = done;
        end
        start = 1'b0;
        n_checks++;
        if (rises !== 3 || done_cyc !== 2)
            $display("FAIL b2b_count got rises=%0d done_cycles=%0d expected 3/2", rises, done_cyc);
        else n_pass++;
        n_checks++;
        if (first_rise !== 33 || second_rise - first_rise !== 34)
            $display("FAIL b2b_period got first=%0d period=%0d expected 33/34", first_rise, second_rise - first_rise);
        else n_pass++;
    endtask

    task automatic test_n1();
        int lat;
        lat = -1;
        golden1 = golden_sig(1);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done1) begin
                lat = k;
                break;
            end
            start1 = (k == 1);
            tick();
            start1 = 1'b0;
        end
        n_checks++;
        if (lat !== 3) $display("FAIL n1_latency got=%0d expected 3", lat);
        else n_pass++;
        n_checks++;
        if (pat_cnt1 !== 5'd1 || pass1 !== 1'b1)
            $display("FAIL n1_result got cnt=%0d pass=%b expected 1/1", pat_cnt1, pass1);
        else n_pass++;
        tick();
        n_checks++;
        if (done1 !== 1'b1) $display("FAIL n1_done_hold got done=%b expected 1", done1);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_mismatch();
        test_abort();
        test_reset_mid_run();
        test_start_during_busy();
        test_back_to_back();
        test_n1();
        repeat (2) tick();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL sb_leftover got=%0d expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bist_ctrl.md
Name: bist_ctrl

Overview:
- Sequencer for the self-test datapath: 5-bit LFSR pattern generator, circuit-under-test check, and 4-bit SISR signature register.
- On a start request it seeds the LFSR, clears the SISR, and enables both for a fixed number of patterns.
- It then compares the final signature against a golden value and reports done/pass.
- Sits between the system test-control logic and the generator/compactor pair; it replaces free-running clocking of the datapath.

Parameters:
- N_PATTERNS, 31, number of RUN cycles (patterns applied); legal range 1..2^CNT_W-1.
- CNT_W, 5, pattern counter width.
- SIG_W, 4, signature width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high; sampled on clk rising edge only.
- start  in  1  level request; sampled only in IDLE and DONE.
- abort  in  1  cancel of a test in progress; sampled in INIT/RUN/CMP.
- golden  in  SIG_W  expected signature; sampled in CMP.
- sig  in  SIG_W  current SISR signature.
- gen_seed  out  1  load LFSR seed (LFSR synchronous load).
- gen_en  out  1  LFSR advance enable.
- sisr_clr  out  1  SISR synchronous clear.
- sisr_en  out  1  SISR compaction enable.
- busy  out  1  high in INIT, RUN, CMP.
- done  out  1  high in DONE.
- pass  out  1  registered result; valid while done=1.
- pat_cnt  out  CNT_W  patterns applied in current run.

Behaviour:
- States: IDLE, INIT, RUN, CMP, DONE. Outputs gen_seed/gen_en/sisr_clr/sisr_en/busy/done are Moore-decoded from state only.
- Reset (rst=1 at edge, any state, including mid-RUN): state=IDLE, pat_cnt=0, pass=0. All outputs are therefore 0 from the cycle after that edge.
- IDLE: start=1 -> INIT; otherwise stay.
- INIT (1 cycle): gen_seed=1, sisr_clr=1, busy=1. Next state RUN; pat_cnt<=0.
- RUN: gen_en=1, sisr_en=1, busy=1. Each edge increments pat_cnt; when pat_cnt==N_PATTERNS-1 at the edge -> CMP, and pat_cnt becomes N_PATTERNS. RUN therefore lasts exactly N_PATTERNS cycles.
- CMP (1 cycle): busy=1, all datapath enables 0, so sig is stable. At the exit edge pass<=(sig==golden); next state DONE.
- DONE: done=1; pass and pat_cnt are held.
  - start=1 -> INIT (immediate restart); pass<=0 at that edge.
  - start=0 -> stay in DONE; done stays asserted until a new start or reset.
- Latency: with the start-sampling edge as E0, done=1 first appears after edge E(N_PATTERNS+2). For the default this is 33 edges.
- abort=1 in INIT, RUN or CMP -> IDLE next edge; pass<=0 and pat_cnt is held for debug. abort is ignored in IDLE and DONE.
- Priority at a single edge: rst > abort > normal transition.
- start held high through an entire run: has no effect while busy. On reaching DONE, the still-high start restarts after one DONE cycle, so done pulses for 1 cycle.
- pat_cnt never wraps: the N_PATTERNS <= 2^CNT_W-1 restriction guarantees this. Synthesis must reject violation via an elaboration check.
- gen_seed and gen_en are never high together; likewise sisr_clr and sisr_en.

Test Plan:
- Nominal pass: rst 2 cycles, golden=SISR signature of a fault-free 31-pattern run, start pulse 1 cycle -> busy for 33 cycles (INIT 1 + RUN 31 + CMP 1); gen_en/sisr_en high exactly 31 cycles; done=1 at edge 33; pass=1; pat_cnt=31.
- Mismatch: same run with golden XOR 4'b0001 -> done=1 at edge 33, pass=0.
- Abort mid-run: abort=1 at 10th RUN cycle -> IDLE next edge; busy=0, done=0, pass=0, pat_cnt=9. A subsequent start runs a full 31 patterns from reseed.
- Reset mid-run: rst=1 during RUN cycle 20 -> next cycle all outputs 0, pat_cnt=0. A start after rst deasserts gives a nominal result identical to test 1.
- Start held continuously: start=1 for 100 cycles -> back-to-back runs; done high 1 cycle per run; period 34 cycles; each run reports the same pass value.
- Start during busy and N_PATTERNS=1: second start pulse in RUN ignored. With N_PATTERNS=1, RUN lasts 1 cycle, done at edge 3, pat_cnt=1.
